// File: rtl/sum_accum_stage.sv
// Frame accumulator behind the adder stage: sums COUNT unsigned samples (or fewer on flush)
// and holds one registered result until taken. Define SUM_ACCUM_SAT_EN to saturate instead of wrap.
module sum_accum_stage #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 9,
   parameter int COUNT = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       IN_valid,
   output logic                       IN_ready,
   input  logic [WIDTH-1:0]           IN_sum,
   input  logic                       IN_flush,
   output logic                       OUT_valid,
   input  logic                       OUT_ready,
   output logic [ACC_W-1:0]           OUT_acc,
   output logic [$clog2(COUNT+1)-1:0] OUT_count,
   output logic                       OUT_ovf
);

   localparam int CNT_W = $clog2(COUNT+1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_EMIT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               emit_d;
   logic               accept;
   logic [ACC_W:0]     add_res;
   logic               out_valid_q;
   logic [ACC_W-1:0]   out_acc_q;
   logic [CNT_W-1:0]   out_count_q;
   logic               out_ovf_q;

   // Returns {carry, new_acc}; once the frame carries, a saturating build pins the sum at full scale,
   // and any later non-zero sample carries again, so saturation is sticky without extra state.
   function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                              input logic [WIDTH-1:0] s);
      logic [ACC_W:0] sum;
      sum = (ACC_W+1)'(a) + (ACC_W+1)'(s);
`ifdef SUM_ACCUM_SAT_EN
      if (sum[ACC_W]) begin
         sum[ACC_W-1:0] = '1;
      end
`endif
      return sum;
   endfunction

   assign IN_ready = (state_q != S_EMIT);
   assign accept   = IN_valid && IN_ready;
   assign add_res  = acc_add(acc_q, IN_sum);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      emit_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d = ACC_W'(IN_sum);
               cnt_d = CNT_ONE;
               ovf_d = 1'b0;
               if (COUNT == 1) begin
                  state_d = S_EMIT;
                  emit_d  = 1'b1;
               end else begin
                  state_d = S_ACCUM;
               end
            end
         end
         S_ACCUM: begin
            if (accept) begin
               acc_d = add_res[ACC_W-1:0];
               cnt_d = cnt_q + CNT_ONE;
               ovf_d = ovf_q | add_res[ACC_W];
            end
            if ((accept && (cnt_d == CNT_LAST)) || IN_flush) begin
               state_d = S_EMIT;
               emit_d  = 1'b1;
            end
         end
         S_EMIT: begin
            if (OUT_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Result register: loaded on the edge that closes a frame, frozen until the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         if (emit_d) begin
            out_valid_q <= 1'b1;
            out_acc_q   <= acc_d;
            out_count_q <= cnt_d;
            out_ovf_q   <= ovf_d;
         end else if ((state_q == S_EMIT) && OUT_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign OUT_valid = out_valid_q;
   assign OUT_acc   = out_acc_q;
   assign OUT_count = out_count_q;
   assign OUT_ovf   = out_ovf_q;

endmodule

// File: tb/tb_sum_accum_stage.sv
// Scoreboard bench for sum_accum_stage: default COUNT=4 instance plus a COUNT=1 instance.
module tb_sum_accum_stage;

   typedef struct packed {
      logic [8:0] acc;
      logic [2:0] cnt;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       IN_valid = 1'b0, IN_flush = 1'b0, OUT_ready = 1'b1;
   logic [7:0] IN_sum = '0;
   logic       IN_ready, OUT_valid, OUT_ovf;
   logic [8:0] OUT_acc;
   logic [2:0] OUT_count;

   logic       v1 = 1'b0, f1 = 1'b0, out1_ready = 1'b0;
   logic [7:0] s1 = '0;
   logic       in1_ready, out1_valid, ovf1;
   logic [8:0] acc1;
   logic [0:0] cnt1;
   logic       tog_en = 1'b0;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   sum_accum_stage #(.WIDTH(8), .ACC_W(9), .COUNT(4)) dut (
      .clk(clk), .rst(rst), .IN_valid(IN_valid), .IN_ready(IN_ready), .IN_sum(IN_sum),
      .IN_flush(IN_flush), .OUT_valid(OUT_valid), .OUT_ready(OUT_ready), .OUT_acc(OUT_acc),
      .OUT_count(OUT_count), .OUT_ovf(OUT_ovf));

   sum_accum_stage #(.WIDTH(8), .ACC_W(9), .COUNT(1)) dut1 (
      .clk(clk), .rst(rst), .IN_valid(v1), .IN_ready(in1_ready), .IN_sum(s1),
      .IN_flush(f1), .OUT_valid(out1_valid), .OUT_ready(out1_ready), .OUT_acc(acc1),
      .OUT_count(cnt1), .OUT_ovf(ovf1));

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor, COUNT=4 instance: every valid cycle is compared, so stability under stall is covered
   always @(negedge clk) begin
      if (OUT_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: acc=%0d count=%0d ovf=%0d", OUT_acc, OUT_count, OUT_ovf);
         end else if (OUT_acc != q[0].acc || OUT_count != q[0].cnt || OUT_ovf != q[0].ovf) begin
            errors++;
            $display("FAIL frame: got acc=%0d count=%0d ovf=%0d, expected acc=%0d count=%0d ovf=%0d",
                     OUT_acc, OUT_count, OUT_ovf, q[0].acc, q[0].cnt, q[0].ovf);
         end
         if (OUT_ready && q.size() != 0) void'(q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (out1_valid) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out1: acc=%0d count=%0d", acc1, cnt1);
         end else if (acc1 != q1[0].acc || 3'(cnt1) != q1[0].cnt || ovf1 != q1[0].ovf) begin
            errors++;
            $display("FAIL frame1: got acc=%0d count=%0d ovf=%0d, expected acc=%0d count=%0d ovf=%0d",
                     acc1, cnt1, ovf1, q1[0].acc, q1[0].cnt, q1[0].ovf);
         end
         if (out1_ready && q1.size() != 0) void'(q1.pop_front());
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (tog_en) out1_ready = ~out1_ready;
   end

   task automatic push(input int acc, input int cnt, input logic ovf);
      exp_t e;
      e.acc = 9'(acc);
      e.cnt = 3'(cnt);
      e.ovf = ovf;
      q.push_back(e);
   endtask

   // Holds the sample until accepted; returns 1 time unit after the accepting edge
   task automatic send(input logic [7:0] s, input logic fl);
      int n;
      n = 0;
      IN_valid = 1'b1;
      IN_sum   = s;
      IN_flush = fl;
      @(negedge clk);
      while (!IN_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!IN_ready) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      IN_flush = 1'b0;
   endtask

   task automatic send1(input logic [7:0] s);
      int n;
      n = 0;
      v1 = 1'b1;
      s1 = s;
      @(negedge clk);
      while (!in1_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in1_ready) chk("send1_timeout", 0, 1);
      @(posedge clk);
      #1;
      v1 = 1'b0;
   endtask

   task automatic idle(input int n);
      IN_valid = 1'b0;
      IN_flush = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e1;
      int   n;
      #3;
      chk("rst_out_valid", OUT_valid, 0);
      chk("rst_out_acc", OUT_acc, 0);
      chk("rst_out_count", OUT_count, 0);
      chk("rst_out_ovf", OUT_ovf, 0);
      chk("rst_in_ready", IN_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1,2,3,4 back-to-back, consumer always ready
      push(10, 4, 1'b0);
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      send(8'd3, 1'b0);
      send(8'd4, 1'b0);
      chk("lat_out_valid", OUT_valid, 1);
      chk("emit_in_ready", IN_ready, 0);
      IN_sum = 8'd5;
      @(posedge clk);
      #1;
      chk("after_emit_out_valid", OUT_valid, 0);
      chk("after_emit_in_ready", IN_ready, 1);

      // 5,6,7,8 with a stalled consumer and a waiting 9
      OUT_ready = 1'b0;
      push(26, 4, 1'b0);
      send(8'd5, 1'b0);
      send(8'd6, 1'b0);
      send(8'd7, 1'b0);
      send(8'd8, 1'b0);
      IN_sum = 8'd9;
      for (int i = 0; i < 6; i++) begin
         chk("stall_in_ready", IN_ready, 0);
         chk("stall_out_valid", OUT_valid, 1);
         @(posedge clk);
         #1;
      end
      OUT_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_out_valid", OUT_valid, 0);
      push(15, 4, 1'b0);
      send(8'd9, 1'b0);
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      send(8'd3, 1'b0);

      // Overflow frame
`ifdef SUM_ACCUM_SAT_EN
      push(511, 4, 1'b1);
`else
      push(508, 4, 1'b1);
`endif
      for (int i = 0; i < 4; i++) send(8'd255, 1'b0);

      // Flush with an accept, then flush alone
      push(21, 3, 1'b0);
      send(8'd7, 1'b0);
      send(8'd9, 1'b0);
      send(8'd5, 1'b1);
      push(7, 1, 1'b0);
      send(8'd7, 1'b0);
      idle(2);
      IN_flush = 1'b1;
      @(posedge clk);
      #1;
      IN_flush = 1'b0;
      chk("flush_out_valid", OUT_valid, 1);
      idle(2);

      // Flush in IDLE produces nothing
      IN_flush = 1'b1;
      @(posedge clk);
      #1;
      IN_flush = 1'b0;
      idle(3);
      chk("idle_flush_out_valid", OUT_valid, 0);

      // Reset mid-frame
      send(8'd3, 1'b0);
      send(8'd4, 1'b0);
      IN_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_acc", OUT_acc, 0);
      chk("midrst_out_count", OUT_count, 0);
      chk("midrst_out_valid", OUT_valid, 0);
      chk("midrst_in_ready", IN_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      push(4, 4, 1'b0);
      for (int i = 0; i < 4; i++) send(8'd1, 1'b0);
      idle(2);

      // COUNT=1 instance with a toggling consumer
      tog_en = 1'b1;
      e1.acc = 9'd0;   e1.cnt = 3'd1; e1.ovf = 1'b0; q1.push_back(e1);
      e1.acc = 9'd200; e1.cnt = 3'd1; e1.ovf = 1'b0; q1.push_back(e1);
      send1(8'd0);
      send1(8'd200);

      n = 0;
      while ((q.size() != 0 || q1.size() != 0) && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("queue_drained", q.size(), 0);
      chk("queue1_drained", q1.size(), 0);
      tog_en = 1'b0;
      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

endmodule
